// File: rtl/seg7_readback_if.sv
// Segment-bus readback handshake: start/seg_bus in, busy/done/value/valid_mask/err out.
// The bench drives through the master modport; the readback core uses the slave modport.
interface seg7_readback_if #(
   parameter int DIGITS = 6
);
   logic                  start;
   logic [7*DIGITS-1:0]   seg_bus;
   logic                  busy;
   logic                  done;
   logic [4*DIGITS-1:0]   value;
   logic [DIGITS-1:0]     valid_mask;
   logic                  err;

   modport master (
      output start,
      output seg_bus,
      input  busy,
      input  done,
      input  value,
      input  valid_mask,
      input  err
   );

   modport slave (
      input  start,
      input  seg_bus,
      output busy,
      output done,
      output value,
      output valid_mask,
      output err
   );
endinterface

// File: rtl/seg7_readback.sv
// Snapshots the active-low segment bus on start and decodes one digit per clock into hex nibbles.
// done pulses DIGITS cycles after the start edge; start is ignored while busy, with no queueing.
module seg7_readback #(
   parameter int DIGITS = 6
) (
   input  logic           i_clk,
   input  logic           i_rst,
   seg7_readback_if.slave bus
);

   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      DONE
   } state_t;

   state_t                r_state;
   logic [7*DIGITS-1:0]   r_snap;
   logic [IW-1:0]         r_idx;
   logic [4*DIGITS-1:0]   r_value;
   logic [DIGITS-1:0]     r_mask;
   logic                  r_err;
   logic                  r_busy;
   logic                  r_done;

   logic [6:0]            w_pat;
   logic [3:0]            w_nib;
   logic                  w_ok;
   logic [4*DIGITS-1:0]   w_value_nxt;
   logic [DIGITS-1:0]     w_mask_nxt;
   logic                  w_last;

   // Pattern bits are a..g from MSB to LSB, active-low; result is {legal, nibble}.
   function automatic logic [4:0] decode(input logic [6:0] p);
      case (p)
         7'b0000001: return {1'b1, 4'h0};
         7'b1001111: return {1'b1, 4'h1};
         7'b0010010: return {1'b1, 4'h2};
         7'b0000110: return {1'b1, 4'h3};
         7'b1001100: return {1'b1, 4'h4};
         7'b0100100: return {1'b1, 4'h5};
         7'b0100000: return {1'b1, 4'h6};
         7'b0001111: return {1'b1, 4'h7};
         7'b0000000: return {1'b1, 4'h8};
         7'b0000100: return {1'b1, 4'h9};
         7'b0001000: return {1'b1, 4'hA};
         7'b1100000: return {1'b1, 4'hB};
         7'b0110001: return {1'b1, 4'hC};
         7'b1000010: return {1'b1, 4'hD};
         7'b0110000: return {1'b1, 4'hE};
         7'b0111000: return {1'b1, 4'hF};
         default:    return 5'b0_0000;
      endcase
   endfunction

   // Digit select and merge use compare loops so an out-of-range index can never
   // produce an out-of-bounds part select.
   always_comb begin
      w_pat = 7'h7F;
      for (int i = 0; i < DIGITS; i++) begin
         if (r_idx == IW'(i)) begin
            w_pat = r_snap[7*i +: 7];
         end
      end
      {w_ok, w_nib} = decode(w_pat);
      w_value_nxt = r_value;
      w_mask_nxt  = r_mask;
      for (int i = 0; i < DIGITS; i++) begin
         if (r_idx == IW'(i)) begin
            w_value_nxt[4*i +: 4] = w_nib;
            w_mask_nxt[i]         = w_ok;
         end
      end
   end

   assign w_last = (r_idx == IW'(DIGITS - 1));

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= IDLE;
         r_snap  <= '0;
         r_idx   <= '0;
         r_value <= '0;
         r_mask  <= '0;
         r_err   <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               if (bus.start) begin
                  r_snap  <= bus.seg_bus;
                  r_value <= '0;
                  r_mask  <= '0;
                  r_err   <= 1'b0;
                  r_idx   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= SCAN;
               end
            end
            SCAN: begin
               r_value <= w_value_nxt;
               r_mask  <= w_mask_nxt;
               if (w_last) begin
                  r_err   <= ~&w_mask_nxt;
                  r_done  <= 1'b1;
                  r_state <= DONE;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy       = r_busy;
   assign bus.done       = r_done;
   assign bus.value      = r_value;
   assign bus.valid_mask = r_mask;
   assign bus.err        = r_err;

endmodule

// File: tb/tb_seg7_readback.sv
// Bench for seg7_readback: vector table of segment buses with expected readback,
// scoreboard queue popped on done, plus snapshot, back-to-back and mid-scan reset sequences.
module tb_seg7_readback;

   localparam int DIGITS = 6;

   typedef struct {
      logic [7*DIGITS-1:0] seg;
      logic [4*DIGITS-1:0] val;
      logic [DIGITS-1:0]   mask;
      logic                err;
   } vec_t;

   logic clk;
   logic rst;
   int   n_chk;
   int   n_err;
   int   cyc;
   vec_t sb[$];
   int   done_cyc[$];
   vec_t vecs[5];

   seg7_readback_if #(.DIGITS(DIGITS)) bus ();

   seg7_readback #(.DIGITS(DIGITS)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [6:0] enc(input logic [3:0] n);
      case (n)
         4'h0: return 7'b0000001;
         4'h1: return 7'b1001111;
         4'h2: return 7'b0010010;
         4'h3: return 7'b0000110;
         4'h4: return 7'b1001100;
         4'h5: return 7'b0100100;
         4'h6: return 7'b0100000;
         4'h7: return 7'b0001111;
         4'h8: return 7'b0000000;
         4'h9: return 7'b0000100;
         4'hA: return 7'b0001000;
         4'hB: return 7'b1100000;
         4'hC: return 7'b0110001;
         4'hD: return 7'b1000010;
         4'hE: return 7'b0110000;
         default: return 7'b0111000;
      endcase
   endfunction

   function automatic logic [7*DIGITS-1:0] mk(input logic [4*DIGITS-1:0] hex);
      logic [7*DIGITS-1:0] b;
      b = '0;
      for (int i = 0; i < DIGITS; i++) b[7*i +: 7] = enc(hex[4*i +: 4]);
      return b;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Scoreboard: every done pulse must match the oldest outstanding capture.
   always @(negedge clk) begin
      if (!rst && bus.done === 1'b1) begin
         vec_t e;
         done_cyc.push_back(cyc);
         if (sb.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL unexpected_done: got done=1 at cycle %0d expected no pulse", cyc);
         end else begin
            e = sb.pop_front();
            check("value", 64'(bus.value), 64'(e.val));
            check("valid_mask", 64'(bus.valid_mask), 64'(e.mask));
            check("err", 64'(bus.err), 64'(e.err));
         end
      end
   end

   task automatic capture(input vec_t v, input logic [7*DIGITS-1:0] seg_after, input bit poke);
      @(posedge clk); #1;
      bus.seg_bus = v.seg;
      bus.start   = 1'b1;
      sb.push_back(v);
      @(posedge clk); #1;
      bus.start   = 1'b0;
      bus.seg_bus = seg_after;
      for (int c = 1; c <= 7; c++) begin
         @(negedge clk);
         check("busy_scan", 64'(bus.busy), 64'd1);
         check("done_timing", 64'(bus.done), (c == 7) ? 64'd1 : 64'd0);
         bus.start = poke && (c == 2 || c == 7);
      end
      @(negedge clk);
      check("busy_after", 64'(bus.busy), 64'd0);
      check("done_after", 64'(bus.done), 64'd0);
      bus.start = 1'b0;
   endtask

   initial begin
      logic [7*DIGITS-1:0] tmp;
      n_chk = 0;
      n_err = 0;
      cyc   = 0;
      rst   = 1'b1;
      bus.start   = 1'b0;
      bus.seg_bus = '0;

      vecs[0] = '{mk(24'h0FA53C), 24'h0FA53C, 6'h3F, 1'b0};
      vecs[1] = '{mk(24'h124678), 24'h124678, 6'h3F, 1'b0};
      vecs[2] = '{mk(24'h9BDE12), 24'h9BDE12, 6'h3F, 1'b0};
      tmp = mk(24'h111111);
      tmp[7*2 +: 7] = 7'b1111110;
      tmp[7*4 +: 7] = 7'b1111111;
      vecs[3] = '{tmp, 24'h101011, 6'b101011, 1'b1};
      vecs[4] = '{{DIGITS{7'b1010101}}, 24'h000000, 6'h00, 1'b1};

      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check("rst_busy", 64'(bus.busy), 64'd0);
         check("rst_done", 64'(bus.done), 64'd0);
         check("rst_value", 64'(bus.value), 64'd0);
         check("rst_mask", 64'(bus.valid_mask), 64'd0);
         check("rst_err", 64'(bus.err), 64'd0);
      end

      foreach (vecs[i]) capture(vecs[i], vecs[i].seg, 1'b0);

      // Results must hold in IDLE until the next accepted start.
      repeat (3) @(negedge clk);
      check("hold_value", 64'(bus.value), 64'(vecs[4].val));
      check("hold_err", 64'(bus.err), 64'd1);

      // Snapshot isolation: bus changes right after the start edge, with start pokes in SCAN and DONE.
      capture('{mk(24'h888888), 24'h888888, 6'h3F, 1'b0}, mk(24'h000000), 1'b1);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check("no_extra_done", 64'(bus.done), 64'd0);
      end

      // Back-to-back: start held for 30 edges yields four captures 8 cycles apart.
      done_cyc.delete();
      @(posedge clk); #1;
      bus.seg_bus = mk(24'h111111);
      bus.start   = 1'b1;
      for (int i = 0; i < 4; i++) sb.push_back('{mk(24'h111111), 24'h111111, 6'h3F, 1'b0});
      repeat (30) @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (12) @(negedge clk);
      check("b2b_count", 64'(done_cyc.size()), 64'd4);
      if (done_cyc.size() == 4) begin
         for (int i = 1; i < 4; i++) check("b2b_period", 64'(done_cyc[i] - done_cyc[i-1]), 64'd8);
      end

      // Asynchronous reset during the third SCAN cycle.
      @(posedge clk); #1;
      bus.seg_bus = mk(24'h111111);
      bus.start   = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      check("pre_rst_busy", 64'(bus.busy), 64'd1);
      rst = 1'b1;
      #1;
      check("arst_busy", 64'(bus.busy), 64'd0);
      check("arst_value", 64'(bus.value), 64'd0);
      check("arst_mask", 64'(bus.valid_mask), 64'd0);
      check("arst_err", 64'(bus.err), 64'd0);
      check("arst_done", 64'(bus.done), 64'd0);
      #2 rst = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check("post_rst_done", 64'(bus.done), 64'd0);
      end

      capture(vecs[0], vecs[0].seg, 1'b0);
      repeat (2) @(negedge clk);
      check("sb_empty", 64'(sb.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish by 200000 expected earlier finish");
      $fatal(1);
   end

endmodule
